// File: rtl/timer_pkg.sv
// Shared defaults and channel state encoding for the multi-channel compare timer.
package timer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;
  localparam int DEF_PRE_W = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/timer_ch.sv
// One compare channel: counts shared ticks while running, emits a one-cycle
// expiry pulse when its counter matches the live period value.
module timer_ch
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [WIDTH-1:0] period,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             busy
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse_d;

  // Priority: clr > stop > start > tick-driven counting.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clr) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end else if (stop) begin
      state_d = CH_IDLE;
    end else if (start) begin
      state_d = CH_RUN;
      cnt_d   = '0;
    end else if (state_q == CH_RUN && tick) begin
      if (cnt_q == period) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
        if (oneshot) state_d = CH_IDLE;
      end else begin
        // A period below the current count lets this wrap through all-ones.
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  assign busy = (state_q == CH_RUN);

endmodule

// File: rtl/timer_mch.sv
// Multi-channel timer: shared prescaler and free-running main counter,
// driving NCH independent compare channels from one internal tick.
module timer_mch
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ena,
  input  logic [PRE_W-1:0]     prescale,
  input  logic [NCH*WIDTH-1:0] period,
  input  logic [NCH-1:0]       oneshot,
  input  logic [NCH-1:0]       ch_start,
  input  logic [NCH-1:0]       ch_stop,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 pulse_full,
  output logic [NCH-1:0]       ch_pulse,
  output logic [NCH-1:0]       ch_busy
);

  logic [PRE_W-1:0] pre_q;
  logic             tick_int;

  // Only an exact match ticks; a value left above a lowered prescale just restarts.
  assign tick_int = ena && !clr && (pre_q == prescale);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_q      <= '0;
      count      <= '0;
      tick       <= 1'b0;
      pulse_full <= 1'b0;
    end else begin
      tick       <= tick_int;
      pulse_full <= tick_int && (count == '1);
      if (ena) pre_q <= (pre_q >= prescale) ? '0 : pre_q + PRE_W'(1);
      if (tick_int) count <= count + WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .tick   (tick_int),
      .period (period[i*WIDTH +: WIDTH]),
      .oneshot(oneshot[i]),
      .start  (ch_start[i]),
      .stop   (ch_stop[i]),
      .pulse  (ch_pulse[i]),
      .busy   (ch_busy[i])
    );
  end

endmodule

// File: tb/tb_timer_mch.sv
// Scoreboard bench for timer_mch: a cycle-level behavioural model queues expected
// outputs as stimulus is issued; a monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_timer_mch;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int PRE_W = 16;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst, clr, ena;
  logic [PRE_W-1:0]     prescale;
  logic [NCH*WIDTH-1:0] period;
  logic [NCH-1:0]       oneshot, ch_start, ch_stop;
  logic [WIDTH-1:0]     count;
  logic                 tick, pulse_full;
  logic [NCH-1:0]       ch_pulse, ch_busy;

  timer_mch #(.WIDTH(WIDTH), .NCH(NCH), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .ena       (ena),
    .prescale  (prescale),
    .period    (period),
    .oneshot   (oneshot),
    .ch_start  (ch_start),
    .ch_stop   (ch_stop),
    .count     (count),
    .tick      (tick),
    .pulse_full(pulse_full),
    .ch_pulse  (ch_pulse),
    .ch_busy   (ch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           count;
    bit           tick;
    bit           full;
    bit [NCH-1:0] pulse;
    bit [NCH-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: ticks elapsed in the prescaler window, main count, channel run/elapsed.
  int m_pre;
  int m_count;
  bit m_run[NCH];
  int m_el[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t model_step();
    exp_t e;
    bit   t;
    int   p;
    e.pulse = '0;
    e.busy  = '0;
    e.full  = 1'b0;
    e.tick  = 1'b0;
    e.count = 0;
    if (rst || clr) begin
      m_pre   = 0;
      m_count = 0;
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 1'b0;
        m_el[i]  = 0;
      end
      return e;
    end
    p = int'(prescale);
    t = ena && (m_pre == p);
    if (ena) m_pre = (m_pre >= p) ? 0 : m_pre + 1;
    e.full = t && (m_count == MAXV);
    if (t) m_count = (m_count + 1) % (MAXV + 1);
    for (int i = 0; i < NCH; i++) begin
      int per;
      per = int'(period[i*WIDTH +: WIDTH]);
      if (ch_stop[i]) begin
        m_run[i] = 1'b0;
      end else if (ch_start[i]) begin
        m_run[i] = 1'b1;
        m_el[i]  = 0;
      end else if (m_run[i] && t) begin
        if (m_el[i] == per) begin
          e.pulse[i] = 1'b1;
          m_el[i]    = 0;
          if (oneshot[i]) m_run[i] = 1'b0;
        end else begin
          m_el[i] = (m_el[i] + 1) % (MAXV + 1);
        end
      end
      e.busy[i] = m_run[i];
    end
    e.tick  = t;
    e.count = m_count;
    return e;
  endfunction

  // One clock: model the edge from the current inputs, queue it, then drop the strobes.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    e = model_step();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ch_start = '0;
    ch_stop  = '0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count", 32'(count), e.count);
      check("tick", 32'(tick), 32'(e.tick));
      check("pulse_full", 32'(pulse_full), 32'(e.full));
      check("ch_pulse", 32'(ch_pulse), 32'(e.pulse));
      check("ch_busy", 32'(ch_busy), 32'(e.busy));
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int fulls, pulses, busy_ok, n, d0, d1;
    bit found;
    rst = 1'b1; clr = 1'b0; ena = 1'b0; prescale = '0;
    period = '0; oneshot = '0; ch_start = '0; ch_stop = '0;
    cycle();
    check("reset_count", 32'(count), 0);
    check("reset_busy", 32'(ch_busy), 0);

    // prescale=3: tick on cycles 4, 8, 12 after reset release
    rst = 1'b0; ena = 1'b1; prescale = PRE_W'(3);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("presc_tick_at", 32'(tick), 32'(k % 4 == 0));
    end
    check("presc_count", 32'(count), 3);

    // main counter wrap with prescale=0
    clr = 1'b1; prescale = '0; cycle(); clr = 1'b0;
    fulls = 0;
    for (int k = 1; k <= 256; k++) begin
      cycle();
      if (pulse_full) fulls++;
    end
    check("wrap_count", 32'(count), 0);
    check("wrap_full_at_wrap", 32'(pulse_full), 1);
    repeat (3) begin
      cycle();
      if (pulse_full) fulls++;
    end
    check("wrap_full_once", fulls, 1);

    // periodic ch0, period 4: pulse every 5 ticks, busy held
    clr = 1'b1; cycle(); clr = 1'b0;
    period[0 +: WIDTH] = WIDTH'(4); oneshot[0] = 1'b0; ch_start[0] = 1'b1;
    cycle();
    pulses = 0; busy_ok = 1;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (ch_pulse[0]) pulses++;
      if (!ch_busy[0]) busy_ok = 0;
      check("per_pulse_at", 32'(ch_pulse[0]), 32'(k % 5 == 0));
    end
    check("per_pulses", pulses, 5);
    check("per_busy_held", busy_ok, 1);

    // one-shot ch1, period 2: one pulse after 3 ticks, busy falls with it
    period[1*WIDTH +: WIDTH] = WIDTH'(2); oneshot[1] = 1'b1; ch_start[1] = 1'b1;
    cycle();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("os_pulse_at", 32'(ch_pulse[1]), 32'(k == 3));
      check("os_busy_at", 32'(ch_busy[1]), 32'(k < 3));
    end

    // start+stop together: stop wins; clr during RUN kills everything
    ch_start[3] = 1'b1; ch_stop[3] = 1'b1; period[3*WIDTH +: WIDTH] = WIDTH'(10);
    cycle();
    check("ss_busy", 32'(ch_busy[3]), 0);
    ch_start[3] = 1'b1; cycle();
    check("ss_restart_busy", 32'(ch_busy[3]), 1);
    repeat (4) cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    check("clr_busy", 32'(ch_busy), 0);
    check("clr_count", 32'(count), 0);
    for (int k = 0; k < 15; k++) begin
      cycle();
      check("clr_no_pulse", 32'(ch_pulse), 0);
    end

    // ena low 10 cycles mid-period delays the one-shot pulse by 10 cycles
    clr = 1'b1; cycle(); clr = 1'b0;
    period[2*WIDTH +: WIDTH] = WIDTH'(5); oneshot[2] = 1'b1; ch_start[2] = 1'b1;
    cycle();
    n = 0; found = 1'b0;
    while (n < 100 && !found) begin
      cycle(); n++;
      if (ch_pulse[2]) found = 1'b1;
    end
    d0 = n;
    check("ena_base_delay", d0, 6);
    ch_start[2] = 1'b1; cycle();
    n = 0;
    repeat (3) begin cycle(); n++; end
    ena = 1'b0;
    repeat (10) begin cycle(); n++; end
    ena = 1'b1; found = 1'b0;
    while (n < 100 && !found) begin
      cycle(); n++;
      if (ch_pulse[2]) found = 1'b1;
    end
    d1 = n;
    check("ena_extra_delay", d1 - d0, 10);
    check("ena_busy_fall", 32'(ch_busy[2]), 0);

    // reset one tick before an expiry: nothing comes out afterwards
    period[0 +: WIDTH] = WIDTH'(2); oneshot[0] = 1'b0; ch_start[0] = 1'b1;
    cycle(); cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rst_no_pulse", 32'(ch_pulse), 0);
      check("rst_idle", 32'(ch_busy), 0);
    end

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      clr = ($urandom_range(0, 99) == 0);
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) prescale = PRE_W'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 49) == 0) period[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 6));
        if ($urandom_range(0, 99) == 0) oneshot[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) ch_start[c] = 1'b1;
        if ($urandom_range(0, 29) == 0) ch_stop[c] = 1'b1;
      end
      cycle();
    end

    rst = 1'b0; clr = 1'b0;
    cycle();
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_mch.md
TIMER_MCH -- requirements
Module: timer_mch

Interface
REQ-001 Parameter WIDTH, default 32, bit width of main counter and channel counters/periods.
REQ-002 Parameter NCH, default 4, number of compare channels (1..16).
REQ-003 Parameter PRE_W, default 16, prescaler width.
REQ-004 clk  input  1  single working clock (110.592 MHz).
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clr  input  1  synchronous clear of prescaler, main counter, all channels and all pulse outputs.
REQ-007 ena  input  1  count enable; low freezes prescaler, main counter and channel counters.
REQ-008 prescale  input  PRE_W  tick divisor minus one; 0 gives a tick on every enabled cycle.
REQ-009 period  input  NCH*WIDTH  per-channel period minus one, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 oneshot  input  NCH  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-011 ch_start  input  NCH  per-channel start strobe, one cycle.
REQ-012 ch_stop  input  NCH  per-channel stop strobe, one cycle.
REQ-013 count  output  WIDTH  free-running main tick counter.
REQ-014 tick  output  1  registered one-cycle prescaler tick.
REQ-015 pulse_full  output  1  one-cycle pulse on main counter wrap.
REQ-016 ch_pulse  output  NCH  one-cycle expiry pulse per channel.
REQ-017 ch_busy  output  NCH  channel running flag.

Function
REQ-018 Prescaler counts 0..prescale on enabled cycles; on reaching prescale it returns to 0 and asserts an internal tick; registered tick output appears 1 cycle later.
REQ-019 prescale change takes effect at the next comparison; a prescaler value above the new prescale restarts at 0 on the next enabled cycle.
REQ-020 count increments by 1 on each internal tick and wraps from all-ones to 0; pulse_full asserts for exactly 1 cycle, in the cycle after the wrap.
REQ-021 Each channel has states IDLE and RUN; ch_start moves IDLE->RUN, loads its counter with 0, and sets ch_busy the next cycle.
REQ-022 ch_start while in RUN restarts the channel counter from 0 without producing a pulse.
REQ-023 In RUN, the channel counter increments on each internal tick; when it equals its period on a tick, it reloads 0 and ch_pulse asserts for 1 cycle in the following cycle.
REQ-024 Periodic channel stays in RUN after expiry; one-shot channel returns to IDLE and deasserts ch_busy in the same cycle ch_pulse asserts.
REQ-025 period 0 gives an expiry on every tick; period is sampled live, so a value below the current count lets the counter wrap through all-ones before expiry.
REQ-026 ch_stop moves RUN->IDLE with no pulse; simultaneous ch_start and ch_stop: stop wins.
REQ-027 Priority per cycle: rst > clr > ch_stop > ch_start > tick-driven counting.
REQ-028 clr zeroes prescaler, count and all channel counters, forces all channels to IDLE, and deasserts tick, pulse_full, ch_pulse and ch_busy on the next cycle.
REQ-029 ena low suppresses ticks; channel states, start and stop still act.

Reset
REQ-030 On rst high at a clk edge, all registers take reset values: count 0, tick 0, pulse_full 0, ch_pulse 0, ch_busy 0, prescaler 0, all channels IDLE.
REQ-031 Reset mid-operation discards any pending expiry; no pulse is emitted after reset.

Structure
REQ-032 Package timer_pkg holds the default WIDTH/NCH/PRE_W constants and the channel state encoding (IDLE=0, RUN=1).
REQ-033 One sub-module timer_ch, one instance per channel via generate, holds the channel counter, state and pulse; the top holds the prescaler and main counter.

Verification
REQ-034 prescale=3, ena=1 -> tick high on cycles 4, 8, 12 after reset release; count=3 after 12 cycles.
REQ-035 WIDTH=8, prescale=0, run 256 ticks -> count wraps 255->0; pulse_full high exactly 1 cycle.
REQ-036 ch0 periodic, period=4, prescale=0, start -> ch_pulse[0] every 5 ticks, ch_busy[0] stays 1.
REQ-037 ch1 one-shot, period=2, start -> single ch_pulse[1] after 3 ticks; ch_busy[1] falls in the same cycle; no further pulses.
REQ-038 ch_start and ch_stop in the same cycle, and a clr during RUN -> channel IDLE, no ch_pulse, count=0.
REQ-039 ena low for 10 cycles mid-period -> pulse delayed by exactly 10 cycles.
